// File: rtl/dual_ram_fifo_ctrl.sv
// Purpose: FIFO controller in front of a dual-port RAM (write port 1, async read port 2); forms a first-word-fall-through FIFO.
// Latency: a word pushed at edge k appears on outData with outValid=1 in the cycle after edge k.
// Backpressure: inReady drops when full or in reset; outData is held stable while outValid=1 and outReady=0.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   inData/inValid/inReady    - producer side (valid/ready)
//   outData/outValid/outReady - consumer side (valid/ready), data straight from ramDataOut2
//   count             - stored words, 0..N
//   ramWr, ramAddr1, ramDataIn - RAM write port (address = write pointer)
//   ramAddr2, ramDataOut2      - RAM read port 2 (address = read pointer)
//   almostFull, almostEmpty    - only when FIFO_ALMOST_FLAGS_EN is defined
//
// Build option: define FIFO_ALMOST_FLAGS_EN to add the almostFull/almostEmpty outputs.
module dual_ram_fifo_ctrl #(
  parameter int N         = 32,
  parameter int Add       = $clog2(N),
  parameter int B         = 8,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [B-1:0]   inData,
  input  logic           inValid,
  output logic           inReady,
  output logic [B-1:0]   outData,
  output logic           outValid,
  input  logic           outReady,
  output logic [Add:0]   count,
  output logic           ramWr,
  output logic [Add-1:0] ramAddr1,
  output logic [Add-1:0] ramAddr2,
  output logic [B-1:0]   ramDataIn,
  input  logic [B-1:0]   ramDataOut2
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic           almostFull,
  output logic           almostEmpty
`endif
);

  // Sized copies of the depth constants so compares and wraps stay width-matched.
  localparam logic [Add:0]   FULL_CNT = (Add+1)'(N);
  localparam logic [Add-1:0] LAST_PTR = Add'(N - 1);

  logic [Add-1:0] wptr;
  logic [Add-1:0] rptr;
  logic [Add:0]   cnt;
  logic           push;
  logic           pop;

  // Reset gates inReady directly so nothing is written to the RAM while rst is held.
  assign inReady  = !rst && (cnt != FULL_CNT);
  assign outValid = (cnt != '0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  assign ramWr     = push;
  assign ramAddr1  = wptr;
  assign ramDataIn = inData;
  assign ramAddr2  = rptr;
  assign outData   = ramDataOut2;
  assign count     = cnt;

  // Explicit wrap on both pointers keeps non-power-of-two depths legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [Add:0] AF_LEVEL = (Add+1)'(N - AF_MARGIN);
  localparam logic [Add:0] AE_LEVEL = (Add+1)'(AE_MARGIN);

  assign almostFull  = (cnt >= AF_LEVEL);
  assign almostEmpty = (cnt <= AE_LEVEL);
`endif

endmodule

// File: tb/tb_dual_ram_fifo_ctrl.sv
module tb_dual_ram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [5:0] count;
  logic       ramWr;
  logic [4:0] ramAddr1;
  logic [4:0] ramAddr2;
  logic [7:0] ramDataIn;
  logic [7:0] ramDataOut2;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almostFull;
  logic       almostEmpty;
`endif

  int nTests = 0;
  int nFail  = 0;

  dual_ram_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .inData     (inData),
    .inValid    (inValid),
    .inReady    (inReady),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .count      (count),
    .ramWr      (ramWr),
    .ramAddr1   (ramAddr1),
    .ramAddr2   (ramAddr2),
    .ramDataIn  (ramDataIn),
    .ramDataOut2(ramDataOut2)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almostFull (almostFull),
    .almostEmpty(almostEmpty)
`endif
  );

  // Behavioural dual-port RAM: synchronous write, asynchronous read on port 2.
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (ramWr) mem[ramAddr1] <= ramDataIn;
  end
  assign ramDataOut2 = mem[ramAddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b1; inData = 8'h11; outReady = 1'b0;
    @(negedge clk);
    #1;
    nTests++; if (inReady !== 1'b0) begin nFail++; $display("FAIL rst_inReady got %b want 0", inReady); end
    nTests++; if (ramWr !== 1'b0) begin nFail++; $display("FAIL rst_ramWr got %b want 0", ramWr); end
    step();
    rst = 1'b0; inValid = 1'b0;
    #1;
    nTests++; if (count !== 6'd0) begin nFail++; $display("FAIL rst_count got %0d want 0", count); end
    nTests++; if (outValid !== 1'b0) begin nFail++; $display("FAIL rst_outValid got %b want 0", outValid); end
    nTests++; if (inReady !== 1'b1) begin nFail++; $display("FAIL rst_inReady_after got %b want 1", inReady); end
    nTests++; if (ramAddr1 !== 5'd0 || ramAddr2 !== 5'd0) begin nFail++; $display("FAIL rst_ptrs got %0d/%0d want 0/0", ramAddr1, ramAddr2); end
`ifdef FIFO_ALMOST_FLAGS_EN
    nTests++; if (almostFull !== 1'b0 || almostEmpty !== 1'b1) begin nFail++; $display("FAIL rst_flags got af=%b ae=%b want 0/1", almostFull, almostEmpty); end
`endif
  endtask

  task automatic test_single_push();
    inValid = 1'b1; inData = 8'hA5; outReady = 1'b0;
    #1;
    nTests++; if (ramWr !== 1'b1 || ramAddr1 !== 5'd0) begin nFail++; $display("FAIL push_wr got wr=%b addr=%0d want 1/0", ramWr, ramAddr1); end
    step();
    inValid = 1'b0;
    #1;
    nTests++; if (outValid !== 1'b1) begin nFail++; $display("FAIL push_outValid got %b want 1", outValid); end
    nTests++; if (outData !== 8'hA5) begin nFail++; $display("FAIL push_outData got %h want a5", outData); end
    nTests++; if (count !== 6'd1) begin nFail++; $display("FAIL push_count got %0d want 1", count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      inValid = 1'b1; inData = 8'(i); outReady = 1'b0;
      #1;
`ifdef FIFO_ALMOST_FLAGS_EN
      nTests++; if (almostEmpty !== (i <= 4)) begin nFail++; $display("FAIL fill_ae cnt=%0d got %b want %b", i, almostEmpty, (i <= 4)); end
      nTests++; if (almostFull !== (i >= 28)) begin nFail++; $display("FAIL fill_af cnt=%0d got %b want %b", i, almostFull, (i >= 28)); end
`endif
      step();
    end
    inData = 8'hEE;
    #1;
    nTests++; if (count !== 6'd32) begin nFail++; $display("FAIL fill_count got %0d want 32", count); end
    nTests++; if (inReady !== 1'b0) begin nFail++; $display("FAIL fill_inReady got %b want 0", inReady); end
    nTests++; if (ramWr !== 1'b0) begin nFail++; $display("FAIL fill_33_ramWr got %b want 0", ramWr); end
`ifdef FIFO_ALMOST_FLAGS_EN
    nTests++; if (almostFull !== 1'b1 || almostEmpty !== 1'b0) begin nFail++; $display("FAIL full_flags got af=%b ae=%b want 1/0", almostFull, almostEmpty); end
`endif
    step();
    inValid = 1'b0;
    #1;
    nTests++; if (count !== 6'd32) begin nFail++; $display("FAIL fill_33_count got %0d want 32", count); end
  endtask

  task automatic test_drain();
    int bad = 0;
    inValid = 1'b0; outReady = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      nTests++;
      if (outValid !== 1'b1 || outData !== 8'(i)) begin
        nFail++;
        if (bad < 4) $display("FAIL drain_word%0d got v=%b d=%h want 1/%h", i, outValid, outData, 8'(i));
        bad++;
      end
      step();
    end
    outReady = 1'b0;
    #1;
    nTests++; if (outValid !== 1'b0 || count !== 6'd0) begin nFail++; $display("FAIL drain_end got v=%b cnt=%0d want 0/0", outValid, count); end
    nTests++; if (ramAddr2 !== 5'd0 || ramAddr1 !== 5'd0) begin nFail++; $display("FAIL drain_ptrs got w=%0d r=%0d want 0/0", ramAddr1, ramAddr2); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      inValid = 1'b1; inData = 8'(8'h40 + i);
      step();
    end
    inData = 8'h77; outReady = 1'b1;
    #1;
    nTests++; if (ramWr !== 1'b0 || outData !== 8'h40) begin nFail++; $display("FAIL fullpp_pre got wr=%b d=%h want 0/40", ramWr, outData); end
    step();
    inValid = 1'b0; outReady = 1'b0;
    #1;
    nTests++; if (count !== 6'd31 || outData !== 8'h41) begin nFail++; $display("FAIL fullpp_post got cnt=%0d d=%h want 31/41", count, outData); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; inData = 8'(8'h80 + i); outReady = 1'b0;
      step();
    end
    for (int k = 0; k < 40; k++) begin
      inValid = 1'b1; inData = 8'(8'h85 + k); outReady = 1'b1;
      #1;
      nTests++;
      if (count !== 6'd5 || outData !== 8'(8'h80 + k) || ramWr !== 1'b1) begin
        nFail++;
        if (bad < 4) $display("FAIL b2b_cycle%0d got cnt=%0d d=%h wr=%b want 5/%h/1", k, count, outData, ramWr, 8'(8'h80 + k));
        bad++;
      end
      step();
    end
    inValid = 1'b0; outReady = 1'b0;
    #1;
    nTests++; if (count !== 6'd5) begin nFail++; $display("FAIL b2b_count got %0d want 5", count); end
    nTests++; if (ramAddr1 !== 5'd13 || ramAddr2 !== 5'd8) begin nFail++; $display("FAIL b2b_ptrs got w=%0d r=%0d want 13/8", ramAddr1, ramAddr2); end
    nTests++; if (outData !== 8'hA8) begin nFail++; $display("FAIL b2b_head got %h want a8", outData); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; inData = 8'(8'hC0 + i); outReady = 1'b0;
      step();
    end
    inValid = 1'b0;
    #1;
    nTests++; if (count !== 6'd10) begin nFail++; $display("FAIL mid_pre_count got %0d want 10", count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    nTests++; if (count !== 6'd0 || outValid !== 1'b0 || inReady !== 1'b1) begin nFail++; $display("FAIL mid_rst got cnt=%0d v=%b rdy=%b want 0/0/1", count, outValid, inReady); end
    inValid = 1'b1; inData = 8'h3C;
    #1;
    nTests++; if (ramWr !== 1'b1 || ramAddr1 !== 5'd0) begin nFail++; $display("FAIL mid_push got wr=%b addr=%0d want 1/0", ramWr, ramAddr1); end
    step();
    inValid = 1'b0;
    #1;
    nTests++; if (count !== 6'd1 || outData !== 8'h3C || outValid !== 1'b1) begin nFail++; $display("FAIL mid_after got cnt=%0d d=%h v=%b want 1/3c/1", count, outData, outValid); end
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inData = 8'h00; outReady = 1'b0;
    test_reset();
    test_single_push();
    test_fill();
    test_drain();
    test_full_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
